// File: rtl/ecrc_pkg.sv
// Shared constants and the sequencer state type for the TL TX ECRC path.
package ecrc_pkg;

    localparam int DATA_ECRC_IN_WIDTH = 256;
    localparam int ECRC_LENGTH_WIDTH  = 6;
    localparam int POLY_WIDTH         = 32;

    localparam logic [31:0] ECRC_SEED = 32'hFFFF_FFFF;

    // PCIe variant bits that enter the ECRC as 1 regardless of their real value
    localparam int TYPE0_BIT = 0;
    localparam int EP_BIT    = 22;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        WAIT_CRC,
        EMIT
    } ecrc_seq_state_e;

endpackage

// File: rtl/ecrc_if.sv
// Port bundle between a requester and the shared ECRC engine.
interface ecrc_if #(
    parameter int DATA_WIDTH = ecrc_pkg::DATA_ECRC_IN_WIDTH,
    parameter int LEN_WIDTH  = ecrc_pkg::ECRC_LENGTH_WIDTH,
    parameter int POLY_WIDTH = ecrc_pkg::POLY_WIDTH
);
    logic [DATA_WIDTH-1:0] CRC_i_Message;
    logic [LEN_WIDTH-1:0]  CRC_i_Length;
    logic                  CRC_i_EN;
    logic [POLY_WIDTH-1:0] CRC_i_Seed;
    logic                  CRC_i_Seed_Load;
    logic [POLY_WIDTH-1:0] CRC_o_CRC;

    modport arbiter_ecrc (
        output CRC_i_Message, CRC_i_Length, CRC_i_EN, CRC_i_Seed, CRC_i_Seed_Load,
        input  CRC_o_CRC
    );

    modport engine (
        input  CRC_i_Message, CRC_i_Length, CRC_i_EN, CRC_i_Seed, CRC_i_Seed_Load,
        output CRC_o_CRC
    );
endinterface

// File: rtl/ecrc_sequencer.sv
// Feeds TLP beats into the shared ECRC engine and hands the complemented
// result to the fragmentation logic over a valid/ready handshake.
module ecrc_sequencer #(
    parameter int DATA_WIDTH = ecrc_pkg::DATA_ECRC_IN_WIDTH,
    parameter int LEN_WIDTH  = ecrc_pkg::ECRC_LENGTH_WIDTH,
    parameter int POLY_WIDTH = ecrc_pkg::POLY_WIDTH,
    parameter logic [POLY_WIDTH-1:0] SEED = POLY_WIDTH'(ecrc_pkg::ECRC_SEED)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_tlp_valid,
    output logic                  o_tlp_ready,
    input  logic [DATA_WIDTH-1:0] i_tlp_data,
    input  logic                  i_tlp_sop,
    input  logic                  i_tlp_eop,
    input  logic [LEN_WIDTH-1:0]  i_tlp_bytes,
    input  logic                  i_tlp_td,
    ecrc_if.arbiter_ecrc          ecrc,
    output logic [POLY_WIDTH-1:0] o_ecrc,
    output logic                  o_ecrc_valid,
    input  logic                  i_ecrc_ready,
    output logic                  o_err
);
    import ecrc_pkg::*;

    localparam logic [LEN_WIDTH-1:0] FULL_LEN = LEN_WIDTH'(DATA_WIDTH / 8);

    ecrc_seq_state_e       state_reg;
    logic                  skip_reg;
    logic [POLY_WIDTH-1:0] ecrc_reg;
    logic                  ecrc_valid_reg;
    logic                  err_reg;

    logic accept;
    logic crc_en;
    logic beat_err;

    // Reset also blocks acceptance so the engine is never touched while in reset
    assign o_tlp_ready = !i_rst && ((state_reg == IDLE) || (state_reg == ACCUM));
    assign accept      = i_tlp_valid && o_tlp_ready;

    // A sop always opens a new TLP, even one that lands in the middle of another
    assign crc_en   = accept && ((i_tlp_sop && i_tlp_td) || (state_reg == ACCUM && !i_tlp_sop));
    assign beat_err = accept && ((state_reg == ACCUM && i_tlp_sop) ||
                                 (state_reg == IDLE && !i_tlp_sop && !skip_reg));

    always_comb begin
        ecrc.CRC_i_EN        = crc_en;
        ecrc.CRC_i_Seed_Load = crc_en && i_tlp_sop;
        ecrc.CRC_i_Seed      = '0;
        ecrc.CRC_i_Length    = '0;
        ecrc.CRC_i_Message   = '0;
        if (crc_en) begin
            ecrc.CRC_i_Length  = i_tlp_eop ? i_tlp_bytes : FULL_LEN;
            ecrc.CRC_i_Message = i_tlp_data;
            if (i_tlp_sop) begin
                ecrc.CRC_i_Seed               = SEED;
                ecrc.CRC_i_Message[TYPE0_BIT] = 1'b1;
                ecrc.CRC_i_Message[EP_BIT]    = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            skip_reg       <= 1'b0;
            ecrc_reg       <= '0;
            ecrc_valid_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            err_reg <= beat_err;
            case (state_reg)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (i_tlp_sop) begin
                            if (i_tlp_td) begin
                                skip_reg  <= 1'b0;
                                state_reg <= i_tlp_eop ? WAIT_CRC : ACCUM;
                            end else begin
                                // td=0 packets are swallowed in IDLE until their eop
                                skip_reg  <= !i_tlp_eop;
                                state_reg <= IDLE;
                            end
                        end else if (state_reg == ACCUM) begin
                            if (i_tlp_eop) begin
                                state_reg <= WAIT_CRC;
                            end
                        end else if (i_tlp_eop) begin
                            skip_reg <= 1'b0;
                        end
                    end
                end
                WAIT_CRC: begin
                    ecrc_reg       <= ~ecrc.CRC_o_CRC;
                    ecrc_valid_reg <= 1'b1;
                    state_reg      <= EMIT;
                end
                EMIT: begin
                    if (i_ecrc_ready) begin
                        ecrc_valid_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_ecrc       = ecrc_reg;
    assign o_ecrc_valid = ecrc_valid_reg;
    assign o_err        = err_reg;

endmodule

// File: tb/tb_ecrc_sequencer.sv
// Bench for ecrc_sequencer: behavioural CRC-32 engine plus a whole-packet
// byte-stream reference for the expected ECRC.
module tb_ecrc_sequencer;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_tlp_valid;
    logic         i_tlp_sop;
    logic         i_tlp_eop;
    logic         i_tlp_td;
    logic         i_ecrc_ready;
    logic [255:0] i_tlp_data;
    logic [5:0]   i_tlp_bytes;
    logic         o_tlp_ready;
    logic         o_ecrc_valid;
    logic         o_err;
    logic [31:0]  o_ecrc;

    int checks    = 0;
    int errors    = 0;
    int tlp_count = 0;

    always #5 i_clk = ~i_clk;

    ecrc_if #(.DATA_WIDTH(256), .LEN_WIDTH(6), .POLY_WIDTH(32)) eng ();

    ecrc_sequencer #(
        .DATA_WIDTH(256),
        .LEN_WIDTH (6),
        .POLY_WIDTH(32),
        .SEED      (32'hFFFF_FFFF)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_tlp_valid (i_tlp_valid),
        .o_tlp_ready (o_tlp_ready),
        .i_tlp_data  (i_tlp_data),
        .i_tlp_sop   (i_tlp_sop),
        .i_tlp_eop   (i_tlp_eop),
        .i_tlp_bytes (i_tlp_bytes),
        .i_tlp_td    (i_tlp_td),
        .ecrc        (eng),
        .o_ecrc      (o_ecrc),
        .o_ecrc_valid(o_ecrc_valid),
        .i_ecrc_ready(i_ecrc_ready),
        .o_err       (o_err)
    );

    // Reflected CRC-32, one byte at a time, LSB first
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
        c = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

    function automatic logic [31:0] engine_step(input logic [31:0] c, input logic [255:0] msg,
                                                input logic [5:0] len);
        for (int i = 0; i < 32; i++) if (i < int'(len)) c = crc32_byte(c, msg[8*i +: 8]);
        return c;
    endfunction

    // External engine: state updates only when enabled, seed replaces state on load
    logic [31:0] engine_crc = 32'h0;
    always @(posedge i_clk)
        if (eng.CRC_i_EN)
            engine_crc <= engine_step(eng.CRC_i_Seed_Load ? eng.CRC_i_Seed : engine_crc,
                                      eng.CRC_i_Message, eng.CRC_i_Length);
    assign eng.CRC_o_CRC = engine_crc;

    // Reference packet
    logic [255:0] beat_data [8];
    logic [255:0] msg_exp   [8];
    int           tlp_n;
    logic         tlp_td;
    logic [5:0]   tlp_last;
    logic [31:0]  exp_crc;
    logic [7:0]   ref_bytes [$];

    // Observations sampled mid-cycle
    logic         obs_ready, obs_en, obs_sl, obs_valid, obs_err;
    logic [5:0]   obs_len;
    logic [255:0] obs_msg;
    logic [31:0]  obs_seed, obs_ecrc;

    function automatic logic [255:0] rand_beat();
        logic [255:0] d;
        for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom();
        return d;
    endfunction

    task automatic build_tlp(input int n, input logic td, input logic [5:0] last, input bit hdr_only);
        logic [255:0] d;
        logic [31:0]  c;
        int           cnt;
        tlp_n = n; tlp_td = td; tlp_last = last;
        ref_bytes.delete();
        for (int b = 0; b < n; b++) begin
            d = rand_beat();
            if (hdr_only) d[255:128] = '0;
            beat_data[b] = d;
            d[0]  = 1'b1;
            d[22] = 1'b1;
            if (b != 0) d = beat_data[b];
            msg_exp[b] = d;
            cnt = (b == n - 1) ? int'(last) : 32;
            for (int i = 0; i < cnt; i++) ref_bytes.push_back(d[8*i +: 8]);
        end
        c = 32'hFFFF_FFFF;
        foreach (ref_bytes[i]) c = crc32_byte(c, ref_bytes[i]);
        exp_crc = ~c;
    endtask

    // One clock cycle: drive at +1 after the edge, sample at the falling edge
    task automatic drive(input logic v, input logic s, input logic e, input logic t,
                         input logic [5:0] nb, input logic [255:0] d);
        i_tlp_valid = v; i_tlp_sop = s; i_tlp_eop = e; i_tlp_td = t;
        i_tlp_bytes = nb; i_tlp_data = d;
        #4;
        obs_ready = o_tlp_ready; obs_valid = o_ecrc_valid; obs_ecrc = o_ecrc; obs_err = o_err;
        obs_en = eng.CRC_i_EN; obs_sl = eng.CRC_i_Seed_Load; obs_len = eng.CRC_i_Length;
        obs_msg = eng.CRC_i_Message; obs_seed = eng.CRC_i_Seed;
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_tlp(input int gap_max);
        logic       last;
        logic [5:0] exp_len;
        for (int b = 0; b < tlp_n; b++) begin
            last = (b == tlp_n - 1);
            if (b > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, '0);
                    checks++;
                    if (obs_ready !== 1'b1 || obs_en !== 1'b0) begin
                        errors++;
                        $display("FAIL gap_idle ready=%0b en=%0b required ready=1 en=0", obs_ready, obs_en);
                    end
                end
            end
            drive(1'b1, b == 0, last, tlp_td, last ? tlp_last : 6'($urandom_range(1, 32)), beat_data[b]);
            checks++;
            if (obs_ready !== 1'b1 || obs_valid !== 1'b0) begin
                errors++;
                $display("FAIL beat_ready tlp %0d beat %0d ready=%0b valid=%0b required 1/0", tlp_count, b, obs_ready, obs_valid);
            end
            checks++;
            if (obs_en !== tlp_td) begin
                errors++;
                $display("FAIL beat_en tlp %0d beat %0d got %0b required %0b", tlp_count, b, obs_en, tlp_td);
            end
            if (b > 0) begin
                checks++;
                if (obs_err !== 1'b0) begin
                    errors++;
                    $display("FAIL beat_err tlp %0d beat %0d got %0b required 0", tlp_count, b, obs_err);
                end
            end
            if (tlp_td) begin
                exp_len = last ? tlp_last : 6'd32;
                checks++;
                if (obs_sl !== (b == 0) || obs_len !== exp_len) begin
                    errors++;
                    $display("FAIL beat_ctl tlp %0d beat %0d seed_load=%0b len=%0d required %0b/%0d", tlp_count, b, obs_sl, obs_len, b == 0, exp_len);
                end
                checks++;
                if (obs_msg !== msg_exp[b]) begin
                    errors++;
                    $display("FAIL beat_msg tlp %0d beat %0d got %h required %h", tlp_count, b, obs_msg[63:0], msg_exp[b][63:0]);
                end
                if (b == 0) begin
                    checks++;
                    if (obs_seed !== 32'hFFFF_FFFF) begin
                        errors++;
                        $display("FAIL beat_seed got %08h required ffffffff", obs_seed);
                    end
                end
            end
        end
        if (!tlp_td) begin
            $display("tlp %0d beats %0d td=0 no ecrc", tlp_count, tlp_n);
            tlp_count++;
        end
    endtask

    // Called right after the eop beat; returns at the first cycle after the handshake
    task automatic expect_ecrc(input int hold);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, '0);
        checks++;
        if (obs_ready !== 1'b0 || obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_crc ready=%0b valid=%0b required 0/0", obs_ready, obs_valid);
        end
        for (int k = 0; k <= hold; k++) begin
            i_ecrc_ready = (k == hold);
            drive(1'b1, 1'b1, 1'b0, 1'b1, 6'd32, rand_beat());
            checks++;
            if (obs_valid !== 1'b1 || obs_ecrc !== exp_crc) begin
                errors++;
                $display("FAIL emit_ecrc tlp %0d cycle %0d valid=%0b ecrc=%08h required 1/%08h", tlp_count, k, obs_valid, obs_ecrc, exp_crc);
            end
            checks++;
            if (obs_ready !== 1'b0 || obs_en !== 1'b0) begin
                errors++;
                $display("FAIL emit_block cycle %0d ready=%0b en=%0b required 0/0", k, obs_ready, obs_en);
            end
        end
        i_ecrc_ready = 1'b0;
        i_tlp_valid  = 1'b0;
        $display("tlp %0d beats %0d ecrc %08h expected %08h", tlp_count, tlp_n, obs_ecrc, exp_crc);
        tlp_count++;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_ecrc_ready = 1'b0;
        i_tlp_valid = 1'b0; i_tlp_sop = 1'b0; i_tlp_eop = 1'b0; i_tlp_td = 1'b0;
        i_tlp_bytes = '0; i_tlp_data = '0;
        @(posedge i_clk);
        #1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 6'd16, rand_beat());
        checks++;
        if (obs_en !== 1'b0 || obs_sl !== 1'b0) begin
            errors++;
            $display("FAIL reset_engine en=%0b seed_load=%0b required 0/0", obs_en, obs_sl);
        end
        i_rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, '0);
        checks++;
        if (obs_ready !== 1'b1 || obs_valid !== 1'b0 || obs_err !== 1'b0 || obs_ecrc !== 32'h0) begin
            errors++;
            $display("FAIL reset_state ready=%0b valid=%0b err=%0b ecrc=%08h required 1/0/0/0", obs_ready, obs_valid, obs_err, obs_ecrc);
        end
    endtask

    task automatic test_single_beat();
        build_tlp(1, 1'b1, 6'd16, 1'b1);
        send_tlp(0);
        expect_ecrc(0);
    endtask

    task automatic test_multi_beat();
        build_tlp(3, 1'b1, 6'd4, 1'b0);
        send_tlp(2);
        expect_ecrc(0);
    endtask

    task automatic test_backpressure();
        build_tlp(2, 1'b1, 6'($urandom_range(1, 32)), 1'b0);
        send_tlp(1);
        expect_ecrc(5);
    endtask

    task automatic test_back_to_back();
        build_tlp(2, 1'b0, 6'd8, 1'b0);
        send_tlp(0);
        build_tlp(1, 1'b0, 6'd32, 1'b0);
        send_tlp(0);
        build_tlp(2, 1'b1, 6'd20, 1'b0);
        send_tlp(0);
        expect_ecrc(0);
    endtask

    task automatic test_errors();
        build_tlp(3, 1'b1, 6'd8, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 6'd32, beat_data[0]);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 6'd32, beat_data[1]);
        build_tlp(2, 1'b1, 6'd20, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 6'd7, beat_data[0]);
        checks++;
        if (obs_en !== 1'b1 || obs_sl !== 1'b1 || obs_msg !== msg_exp[0]) begin
            errors++;
            $display("FAIL sop_in_accum en=%0b seed_load=%0b required 1/1", obs_en, obs_sl);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1, tlp_last, beat_data[1]);
        checks++;
        if (obs_err !== 1'b1 || obs_sl !== 1'b0 || obs_len !== tlp_last) begin
            errors++;
            $display("FAIL sop_in_accum_err err=%0b seed_load=%0b len=%0d required 1/0/%0d", obs_err, obs_sl, obs_len, tlp_last);
        end
        expect_ecrc(0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 6'd5, rand_beat());
        checks++;
        if (obs_en !== 1'b0 || obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL stray_beat en=%0b ready=%0b required 0/1", obs_en, obs_ready);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, '0);
        checks++;
        if (obs_err !== 1'b1) begin
            errors++;
            $display("FAIL stray_err got %0b required 1", obs_err);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, '0);
        checks++;
        if (obs_err !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse_width got %0b required 0", obs_err);
        end
    endtask

    task automatic test_reset_mid();
        build_tlp(3, 1'b1, 6'd12, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 6'd32, beat_data[0]);
        i_rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 6'd32, beat_data[1]);
        checks++;
        if (obs_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_engine en=%0b required 0", obs_en);
        end
        i_rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, '0);
        checks++;
        if (obs_ready !== 1'b1 || obs_valid !== 1'b0 || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle ready=%0b valid=%0b err=%0b required 1/0/0", obs_ready, obs_valid, obs_err);
        end
        build_tlp(1, 1'b1, 6'd32, 1'b0);
        send_tlp(0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, '0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, '0);
        checks++;
        if (obs_valid !== 1'b1 || obs_ecrc !== exp_crc) begin
            errors++;
            $display("FAIL pre_reset_emit valid=%0b ecrc=%08h required 1/%08h", obs_valid, obs_ecrc, exp_crc);
        end
        i_rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, '0);
        i_rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, '0);
        checks++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1 || obs_ecrc !== 32'h0) begin
            errors++;
            $display("FAIL reset_emit valid=%0b ready=%0b ecrc=%08h required 0/1/0", obs_valid, obs_ready, obs_ecrc);
        end
        build_tlp(3, 1'b1, 6'($urandom_range(1, 32)), 1'b0);
        send_tlp(1);
        expect_ecrc(1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            build_tlp($urandom_range(1, 4), 1'($urandom_range(0, 1)), 6'($urandom_range(1, 32)), 1'b0);
            send_tlp(2);
            if (tlp_td) expect_ecrc($urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_backpressure();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
